// File: rtl/wddl_pkg.sv
// Shared types and the monotonic dual-rail NOR primitive for the WDDL gate stages.
// Every stage imports this package so that they all agree on rail encoding.
package wddl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRECH = 2'd1,
        EVAL  = 2'd2
    } phase_e;

    localparam int PH_CNT_W  = 4;
    localparam int MAX_FANIN = 8;

    typedef struct packed {
        logic t;
        logic f;
    } rail_t;

    // One bit position gathered across all operands, with operand j at index j.
    typedef logic [MAX_FANIN-1:0] col_t;

    // Unused operand slots must be padded with t=0, f=1 so that they are neutral.
    function automatic rail_t wddl_nor(input col_t op_t, input col_t op_f);
        rail_t r;
        r.t = &op_f;
        r.f = |op_t;
        return r;
    endfunction

endpackage

// File: rtl/wddl_phase_ctrl.sv
// Precharge/evaluate sequencer for a WDDL stage: phase FSM, phase counter,
// registered phase flag, wave-complete pulse and completed-wave counter.
module wddl_phase_ctrl
    import wddl_pkg::*;
#(
    parameter int PRECH_CYCLES = 1,
    parameter int EVAL_CYCLES  = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output phase_e           state,
    output logic             is_last_eval,
    output logic             is_prech,
    output logic             phase_eval,
    output logic             out_vld,
    output logic [CNT_W-1:0] wave_cnt
);

    localparam logic [PH_CNT_W-1:0] PRECH_LAST = PH_CNT_W'(PRECH_CYCLES - 1);
    localparam logic [PH_CNT_W-1:0] EVAL_LAST  = PH_CNT_W'(EVAL_CYCLES - 1);

    phase_e              state_q;
    phase_e              state_d;
    logic [PH_CNT_W-1:0] cnt_q;
    logic [PH_CNT_W-1:0] cnt_d;

    assign state = state_q;

    // en is only looked at in IDLE and on the last EVAL cycle, so a wave never aborts.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that skipped
        // an assignment would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_last_eval = 1'b0;
        is_prech     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = PRECH;
                    cnt_d   = '0;
                end
            end
            PRECH: begin
                is_prech = 1'b1;
                if (cnt_q == PRECH_LAST) begin
                    state_d = EVAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PH_CNT_W'(1);
                end
            end
            EVAL: begin
                if (cnt_q == EVAL_LAST) begin
                    is_last_eval = 1'b1;
                    state_d      = en ? PRECH : IDLE;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + PH_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // phase_eval is registered from the next state so it is high exactly while in EVAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            phase_eval <= 1'b0;
            out_vld    <= 1'b0;
            wave_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_eval <= (state_d == EVAL);
            out_vld    <= is_last_eval;
            if (is_last_eval) begin
                wave_cnt <= wave_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wddl_nor_stage.sv
// WDDL dual-rail FANIN-input NOR pipeline stage with its own phase sequencer
// and sticky rail-integrity flags; outputs lag the phase by one cycle.
module wddl_nor_stage
    import wddl_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int FANIN        = 2,
    parameter int PRECH_CYCLES = 1,
    parameter int EVAL_CYCLES  = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [FANIN*WIDTH-1:0] in_t,
    input  logic [FANIN*WIDTH-1:0] in_f,
    input  logic                   err_clr,
    output logic [WIDTH-1:0]       out_t,
    output logic [WIDTH-1:0]       out_f,
    output logic                   phase_eval,
    output logic                   out_vld,
    output logic                   err_collision,
    output logic                   err_incomplete,
    output logic                   err_prech,
    output logic [CNT_W-1:0]       wave_cnt
);

    phase_e           state;
    logic             is_last_eval;
    logic             is_prech;
    logic             in_eval;
    col_t             cols_t [WIDTH];
    col_t             cols_f [WIDTH];
    rail_t            rails  [WIDTH];
    logic [WIDTH-1:0] nor_t;
    logic [WIDTH-1:0] nor_f;
    logic             set_collision;
    logic             set_incomplete;
    logic             set_prech;

    wddl_phase_ctrl #(
        .PRECH_CYCLES (PRECH_CYCLES),
        .EVAL_CYCLES  (EVAL_CYCLES),
        .CNT_W        (CNT_W)
    ) u_phase_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .state        (state),
        .is_last_eval (is_last_eval),
        .is_prech     (is_prech),
        .phase_eval   (phase_eval),
        .out_vld      (out_vld),
        .wave_cnt     (wave_cnt)
    );

    assign in_eval = (state == EVAL);

    // Gather each bit position across operands; spare slots are padded neutral.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cols_t[i] = '0;
            cols_f[i] = '1;
            for (int j = 0; j < FANIN; j++) begin
                cols_t[i][j] = in_t[j*WIDTH + i];
                cols_f[i][j] = in_f[j*WIDTH + i];
            end
            rails[i] = wddl_nor(cols_t[i], cols_f[i]);
            nor_t[i] = rails[i].t;
            nor_f[i] = rails[i].f;
        end
    end

    assign set_collision  = in_eval      && |(in_t & in_f);
    assign set_incomplete = is_last_eval && |(~(in_t | in_f));
    assign set_prech      = is_prech     && |(in_t | in_f);

    // Outside EVAL the register loads zeros so downstream sees a clean precharge wave.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, including the data path, is cleared by the
        // asynchronous reset so the outputs are 0 the moment rst_n falls.
        if (!rst_n) begin
            out_t          <= '0;
            out_f          <= '0;
            err_collision  <= 1'b0;
            err_incomplete <= 1'b0;
            err_prech      <= 1'b0;
        end else begin
            out_t          <= in_eval ? nor_t : '0;
            out_f          <= in_eval ? nor_f : '0;
            err_collision  <= set_collision  | (err_collision  & ~err_clr);
            err_incomplete <= set_incomplete | (err_incomplete & ~err_clr);
            err_prech      <= set_prech      | (err_prech      & ~err_clr);
        end
    end

endmodule

// File: tb/tb_wddl_nor_stage.sv
// Scoreboard bench for wddl_nor_stage: the driver walks whole waves and pushes the
// expected result of each wave; a monitor pops and compares on every out_vld.
module tb_wddl_nor_stage;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int P  = 2;
    localparam int E  = 3;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en = 1'b0;
    logic           err_clr = 1'b0;
    logic [N*W-1:0] in_t = '0;
    logic [N*W-1:0] in_f = '0;
    logic [W-1:0]   out_t;
    logic [W-1:0]   out_f;
    logic           phase_eval;
    logic           out_vld;
    logic           err_collision;
    logic           err_incomplete;
    logic           err_prech;
    logic [CW-1:0]  wave_cnt;

    always #5 clk = ~clk;

    wddl_nor_stage #(
        .WIDTH        (W),
        .FANIN        (N),
        .PRECH_CYCLES (P),
        .EVAL_CYCLES  (E),
        .CNT_W        (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .in_t           (in_t),
        .in_f           (in_f),
        .err_clr        (err_clr),
        .out_t          (out_t),
        .out_f          (out_f),
        .phase_eval     (phase_eval),
        .out_vld        (out_vld),
        .err_collision  (err_collision),
        .err_incomplete (err_incomplete),
        .err_prech      (err_prech),
        .wave_cnt       (wave_cnt)
    );

    typedef struct {
        logic [W-1:0] t;
        logic [W-1:0] f;
        int           cnt;
        bit           coll;
        bit           inc;
        bit           pre;
    } exp_t;

    typedef enum {K_IDLE, K_PRECH, K_EVAL, K_LAST} kind_e;
    typedef enum {M_RAND, M_PLAN, M_ZERO, M_COLL, M_CLEAN, M_CLEAN_CLR,
                  M_INC, M_PRECH_CLR, M_COLL_CLR} mode_e;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   m_coll  = 0;
    bit   m_inc   = 0;
    bit   m_pre   = 0;
    int   m_waves = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // NOR of dual-rail operands: true when every operand is false, false when any is true.
    function automatic void model_nor(input logic [N*W-1:0] t, input logic [N*W-1:0] f,
                                      output logic [W-1:0] rt, output logic [W-1:0] rf);
        rt = '1;
        rf = '0;
        for (int j = 0; j < N; j++) begin
            rt = rt & f[j*W +: W];
            rf = rf | t[j*W +: W];
        end
    endfunction

    // Drives one cycle whose FSM phase is k; the model is advanced to the closing edge.
    task automatic drive_cycle(input kind_e k, input logic [N*W-1:0] t, input logic [N*W-1:0] f,
                               input bit en_v, input bit clr);
        bit   ev;
        bit   sc;
        bit   si;
        bit   sp;
        exp_t e;
        @(negedge clk);
        ev = (k == K_EVAL) || (k == K_LAST);
        check("phase_eval", 32'(phase_eval), 32'(ev));
        in_t    = t;
        in_f    = f;
        en      = en_v;
        err_clr = clr;
        sc = ev && ((t & f) != '0);
        si = (k == K_LAST) && ((t | f) != {N*W{1'b1}});
        sp = (k == K_PRECH) && ((t | f) != '0);
        m_coll = sc | (m_coll & !clr);
        m_inc  = si | (m_inc & !clr);
        m_pre  = sp | (m_pre & !clr);
        if (k == K_LAST) begin
            m_waves++;
            model_nor(t, f, e.t, e.f);
            e.cnt  = m_waves % (1 << CW);
            e.coll = m_coll;
            e.inc  = m_inc;
            e.pre  = m_pre;
            sb.push_back(e);
        end
    endtask

    function automatic void valid_ops(output logic [N*W-1:0] t, output logic [N*W-1:0] f);
        logic [W-1:0] v;
        for (int j = 0; j < N; j++) begin
            v = W'($urandom);
            t[j*W +: W] = v;
            f[j*W +: W] = ~v;
        end
    endfunction

    task automatic idle_cycles(input int n, input bit en_last);
        for (int k = 0; k < n; k++) begin
            drive_cycle(K_IDLE, (N*W)'($urandom), (N*W)'($urandom),
                        (k == n - 1) ? en_last : 1'b0, $urandom_range(0, 7) == 0);
        end
    endtask

    // Assumes en was sampled high, so the next cycle is the first PRECH cycle.
    task automatic run_wave(input mode_e mode, input bit cont);
        logic [N*W-1:0] t;
        logic [N*W-1:0] f;
        bit             clr;
        bit             last;
        int             pos;
        for (int p = 0; p < P; p++) begin
            t   = '0;
            f   = '0;
            clr = (mode == M_RAND) && ($urandom_range(0, 9) == 0);
            if (mode == M_RAND && $urandom_range(0, 15) == 0) begin
                pos = $urandom_range(0, N*W - 1);
                if ($urandom_range(0, 1) == 1) t[pos] = 1'b1;
                else f[pos] = 1'b1;
            end
            if (p == 0 && mode == M_PRECH_CLR) begin
                t[5] = 1'b1;
                clr  = 1'b1;
            end
            if (p == 0 && mode == M_CLEAN_CLR) clr = 1'b1;
            drive_cycle(K_PRECH, t, f, 1'($urandom_range(0, 1)), clr);
        end
        for (int e = 0; e < E; e++) begin
            last = (e == E - 1);
            clr  = 1'b0;
            case (mode)
                M_PLAN: begin
                    t = '0;
                    t[0 +: W] = W'(8'h0F);
                    t[W +: W] = W'(8'h30);
                    f = ~t;
                end
                M_ZERO: begin
                    t = '0;
                    f = '1;
                end
                default: valid_ops(t, f);
            endcase
            if (mode == M_RAND) begin
                clr = ($urandom_range(0, 9) == 0);
                pos = $urandom_range(0, N*W - 1);
                case ($urandom_range(0, 11))
                    0: begin t[pos] = 1'b1; f[pos] = 1'b1; end
                    1: begin t[pos] = 1'b0; f[pos] = 1'b0; end
                    default: ;
                endcase
            end
            if ((mode == M_COLL && e == 0) || (mode == M_COLL_CLR && last)) begin
                t[W + 2] = 1'b1;
                f[W + 2] = 1'b1;
                clr      = (mode == M_COLL_CLR);
            end
            if (mode == M_INC && last) begin
                t[0] = 1'b0;
                f[0] = 1'b0;
            end
            drive_cycle(last ? K_LAST : K_EVAL, t, f, last ? cont : 1'($urandom_range(0, 1)), clr);
        end
    endtask

    // Monitor: each out_vld consumes one expected wave; the cycle after must be precharge zeros.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_vld) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_vld", 32'(out_vld), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_t", 32'(out_t), 32'(e.t));
                    check("out_f", 32'(out_f), 32'(e.f));
                    check("wave_cnt", 32'(wave_cnt), 32'(e.cnt));
                    check("err_collision", 32'(err_collision), 32'(e.coll));
                    check("err_incomplete", 32'(err_incomplete), 32'(e.inc));
                    check("err_prech", 32'(err_prech), 32'(e.pre));
                end
                @(posedge clk);
                #1;
                check("prech_zero_rails", 32'({out_t, out_f}), 32'd0);
                check("out_vld_single_pulse", 32'(out_vld), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mode_e          plan [9];
        logic [N*W-1:0] t;
        logic [N*W-1:0] f;
        logic [N*W-1:0] pt;
        bit             cont;
        plan = '{M_PLAN, M_ZERO, M_COLL, M_CLEAN, M_CLEAN, M_CLEAN_CLR,
                 M_INC, M_PRECH_CLR, M_COLL_CLR};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        check("rst_out_t", 32'(out_t), 32'd0);
        check("rst_out_f", 32'(out_f), 32'd0);
        check("rst_phase_eval", 32'(phase_eval), 32'd0);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_errs", 32'({err_collision, err_incomplete, err_prech}), 32'd0);
        check("rst_wave_cnt", 32'(wave_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idle_cycles(2, 1'b1);
        foreach (plan[i]) run_wave(plan[i], 1'b1);
        for (int w = 0; w < 32; w++) begin
            cont = ($urandom_range(0, 3) != 0);
            run_wave(M_RAND, cont);
            if (!cont) idle_cycles($urandom_range(1, 3), 1'b1);
        end

        // Asynchronous reset in the middle of EVAL, with data, a flag and the counter live.
        pt    = '0;
        pt[5] = 1'b1;
        drive_cycle(K_PRECH, pt, '0, 1'b1, 1'b0);
        for (int p = 1; p < P; p++) drive_cycle(K_PRECH, '0, '0, 1'b1, 1'b0);
        valid_ops(t, f);
        drive_cycle(K_EVAL, t, f, 1'b1, 1'b0);
        valid_ops(t, f);
        drive_cycle(K_EVAL, t, f, 1'b1, 1'b0);
        check("pre_rst_rails", 32'(out_t | out_f), 32'(8'hFF));
        check("pre_rst_err_prech", 32'(err_prech), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rails", 32'({out_t, out_f}), 32'd0);
        check("async_rst_phase_eval", 32'(phase_eval), 32'd0);
        check("async_rst_errs", 32'({err_collision, err_incomplete, err_prech}), 32'd0);
        check("async_rst_wave_cnt", 32'(wave_cnt), 32'd0);
        m_coll  = 0;
        m_inc   = 0;
        m_pre   = 0;
        m_waves = 0;
        @(negedge clk);
        in_t  = '0;
        in_f  = '0;
        en    = 1'b0;
        rst_n = 1'b1;
        idle_cycles(3, 1'b1);
        run_wave(M_PLAN, 1'b1);
        run_wave(M_RAND, 1'b0);
        idle_cycles(3, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wddl_nor_stage.md
Name: wddl_nor_stage

Overview:
- Parametrised WDDL (wave dynamic differential logic) dual-rail NOR stage for the AES datapath.
- Performs a WIDTH-wide, FANIN-input NOR on dual-rail operands and registers the result.
- Contains its own precharge/evaluate phase sequencer and sticky rail-integrity error flags.
- Sits between combinational WDDL gate networks as a phase-aligned pipeline register.

Parameters:
- WIDTH, 8, number of dual-rail bits per operand.
- FANIN, 2, number of NOR operands; legal range 2..8.
- PRECH_CYCLES, 1, cycles spent in precharge per wave; legal range 1..15.
- EVAL_CYCLES, 1, cycles spent in evaluate per wave; legal range 1..15.
- CNT_W, 16, width of the completed-wave counter.

Ports:
- clk  input  1  stage clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run request for the phase sequencer.
- in_t  input  FANIN*WIDTH  true rails; bit i of operand j is at index j*WIDTH+i.
- in_f  input  FANIN*WIDTH  false rails; same indexing as in_t.
- err_clr  input  1  synchronous clear of all sticky error flags.
- out_t  output  WIDTH  registered true rail of the NOR result.
- out_f  output  WIDTH  registered false rail of the NOR result.
- phase_eval  output  1  registered; 1 while in EVAL, 0 otherwise.
- out_vld  output  1  one-cycle pulse on the cycle after the last EVAL cycle.
- err_collision  output  1  sticky; an input pair was (1,1) during EVAL.
- err_incomplete  output  1  sticky; an input pair was (0,0) in the last EVAL cycle.
- err_prech  output  1  sticky; an input rail was 1 during PRECH.
- wave_cnt  output  CNT_W  number of completed EVAL phases; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE, phase counter is 0, and every output is 0.
- FSM states: IDLE, PRECH, EVAL. The phase counter is 4 bits.
- IDLE: if en=1, go to PRECH with counter=0.
- PRECH: after PRECH_CYCLES cycles, go to EVAL with counter=0.
- EVAL, last cycle (counter=EVAL_CYCLES-1): if en=1 go to PRECH, otherwise go to IDLE.
- en is sampled only in IDLE and on the last EVAL cycle. A mid-wave deassert finishes the current wave; it never aborts.
- Gate function, monotonic WDDL form:
  - nor_t[i] = AND over j of in_f[j*WIDTH+i].
  - nor_f[i] = OR over j of in_t[j*WIDTH+i].
- Output register behaviour:
  - In an EVAL cycle: out_t <= nor_t and out_f <= nor_f.
  - In PRECH or IDLE: out_t and out_f are loaded with all zeros.
  - Latency is 1 cycle. Outputs lag the state by one cycle, so downstream sees a clean all-zero precharge wave.
- phase_eval is registered and asserts in the cycle the FSM is in EVAL.
- out_vld pulses for 1 cycle on the clock after the last EVAL cycle.
  - In that same cycle, out_t/out_f still hold the final EVAL result, because the output register lags.
- wave_cnt increments by 1 on each last EVAL cycle and wraps to 0 after 2^CNT_W-1.
- Integrity checks, evaluated per bit per operand; all flags are sticky:
  - EVAL, any cycle, in_t & in_f = 1 -> set err_collision.
  - Last EVAL cycle, in_t | in_f = 0 -> set err_incomplete.
  - PRECH, in_t | in_f = 1 -> set err_prech.
  - IDLE: no checks are performed.
- err_clr=1 clears all three flags. If a set condition occurs in the same cycle as err_clr, set wins.
- Errors do not alter sequencing or data. The output still registers the computed rails, including (1,1) values.

Decomposition:
- Package wddl_pkg holds:
  - enum phase_e {IDLE, PRECH, EVAL} on 2 bits.
  - localparam PH_CNT_W = 4.
  - typedef rail_t: struct of logic t and logic f.
  - A function wddl_nor(): operand arrays in, rail vector out, shared with other WDDL gate stages.
- Sub-module wddl_phase_ctrl:
  - Owns the FSM, the phase counter, phase_eval, out_vld and wave_cnt.
  - Exports state, is_last_eval and is_prech strobes to the data/check logic in wddl_nor_stage.

Test Plan:
1. Defaults, reset, then en=1, operand A=0x0F and B=0x30 driven as valid dual-rail in EVAL and all-zero in PRECH -> out_t=0xC0 and out_f=0x3F one cycle after the EVAL cycle; out_vld pulses; wave_cnt=1; out is 0x00/0x00 in the following precharge cycle; no errors.
2. PRECH_CYCLES=3, EVAL_CYCLES=2, en held high for 4 waves -> phase_eval is 0,0,0,1,1 repeating; out_vld fires 4 times, spaced 5 cycles; wave_cnt=4.
3. Bit 2 of operand 1 driven to (1,1) during EVAL -> err_collision=1 and stays set through subsequent clean waves; err_clr pulse -> flag returns to 0 the next cycle.
4. Bit 0 of operand 0 left at (0,0) in the last EVAL cycle -> err_incomplete=1. Separately, in_t[5]=1 during PRECH -> err_prech=1. Set together with err_clr in the same cycle -> the flag stays 1.
5. en dropped in the middle of EVAL (EVAL_CYCLES=3) -> the wave completes, out_vld pulses, and the FSM enters IDLE with outputs at 0. Separately, rst_n asserted mid-EVAL -> all outputs 0 immediately (asynchronously), and the FSM is in IDLE.
6. CNT_W=4, run 17 waves -> wave_cnt wraps 15 -> 0 -> 1. FANIN=4, WIDTH=16 with all operands 0x0000 -> out_t=0xFFFF and out_f=0x0000.
